// File: rtl/issue_scoreboard.sv
// ---------------------------------------------------------------------------
// issue_scoreboard
//
// Issue controller and register scoreboard between decode and execute.
// Each cycle one decoded instruction is checked for RAW/WAW hazards against
// the busy-register table and for availability of its target unit. When
// every check passes, the instruction issues: a registered one-hot unit
// enable pulses for one cycle, the destination fields are registered out,
// and the destination registers are marked busy. Writeback strobes clear
// busy bits. Register 0 is hardwired zero and is never busy.
//
// Optional feature (compile-time macro ISSUE_WB_BYPASS_EN):
//   defined     - hazard checks see this cycle's writebacks, so a consumer
//                 issues in the same cycle as its producer's writeback strobe.
//   not defined - hazard checks use the registered busy table only
//                 (consumer issues one cycle later, shorter in_ready path).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        decoded instruction present / accepted (comb.)
//   in_unit                    target execution unit index
//   in_rs1_rn/_en, in_rs2_rn/_en  source registers and their use flags
//   in_rd_rn/_en, in_rd2_rn/_en   destination registers and write flags
//   unit_busy                  per-unit busy from execute
//   wb_rn, wb_en               writeback ports, port k at wb_rn[k*RNW +: RNW]
//   unit_en                    registered one-hot issue pulse
//   ex_rd_rn/_en, ex_rd2_rn/_en   registered destinations of issued instr.
//   reg_busy                   scoreboard bits
//   stall_cnt                  saturating count of in_valid & ~in_ready cycles
// ---------------------------------------------------------------------------
module issue_scoreboard #(
    parameter int NUM_UNITS = 5,
    parameter int NUM_REGS  = 64,
    parameter int NUM_WB    = 2,
    parameter int RNW       = $clog2(NUM_REGS),
    parameter int UW        = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [UW-1:0]         in_unit,
    input  logic [RNW-1:0]        in_rs1_rn,
    input  logic [RNW-1:0]        in_rs2_rn,
    input  logic                  in_rs1_en,
    input  logic                  in_rs2_en,
    input  logic [RNW-1:0]        in_rd_rn,
    input  logic [RNW-1:0]        in_rd2_rn,
    input  logic                  in_rd_en,
    input  logic                  in_rd2_en,
    input  logic [NUM_UNITS-1:0]  unit_busy,
    input  logic [NUM_WB*RNW-1:0] wb_rn,
    input  logic [NUM_WB-1:0]     wb_en,
    output logic [NUM_UNITS-1:0]  unit_en,
    output logic [RNW-1:0]        ex_rd_rn,
    output logic [RNW-1:0]        ex_rd2_rn,
    output logic                  ex_rd_en,
    output logic                  ex_rd2_en,
    output logic [NUM_REGS-1:0]   reg_busy,
    output logic [15:0]           stall_cnt
);

    localparam int UNIT_SPAN = 1 << UW;

    logic [NUM_REGS-1:0]  reg_busy_q, reg_busy_d;
    logic [NUM_UNITS-1:0] unit_en_q, unit_en_d;
    logic [RNW-1:0]       ex_rd_rn_q, ex_rd_rn_d;
    logic [RNW-1:0]       ex_rd2_rn_q, ex_rd2_rn_d;
    logic                 ex_rd_en_q, ex_rd_en_d;
    logic                 ex_rd2_en_q, ex_rd2_en_d;
    logic [15:0]          stall_cnt_q, stall_cnt_d;

    logic [NUM_REGS-1:0]  wb_clear_mask;
    logic [NUM_REGS-1:0]  busy_chk;
    logic [NUM_REGS-1:0]  set_mask;
    logic [UNIT_SPAN-1:0] unit_busy_ext;
    logic                 unit_ok;
    logic                 raw_hz;
    logic                 waw_hz;
    logic                 unit_hz;
    logic                 issue;

    // Decode all writeback ports into one clear mask; duplicates just OR.
    always_comb begin
        wb_clear_mask = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            if (wb_en[k]) begin
                wb_clear_mask[wb_rn[k*RNW +: RNW]] = 1'b1;
            end
        end
    end

    // Hazard and issue decision.
    always_comb begin
`ifdef ISSUE_WB_BYPASS_EN
        busy_chk = reg_busy_q & ~wb_clear_mask;
`else
        busy_chk = reg_busy_q;
`endif
        // Pad unit_busy to a power-of-two span so any in_unit value indexes
        // safely; the out-of-range case is rejected by unit_ok anyway.
        unit_busy_ext                = '0;
        unit_busy_ext[NUM_UNITS-1:0] = unit_busy;

        unit_ok = ({1'b0, in_unit} < (UW+1)'(NUM_UNITS));
        raw_hz  = (in_rs1_en & busy_chk[in_rs1_rn]) | (in_rs2_en & busy_chk[in_rs2_rn]);
        waw_hz  = (in_rd_en  & busy_chk[in_rd_rn])  | (in_rd2_en & busy_chk[in_rd2_rn]);
        unit_hz = unit_busy_ext[in_unit];
        issue   = in_valid & ~raw_hz & ~waw_hz & ~unit_hz & unit_ok;
    end

    // Next-state for the scoreboard and the registered issue outputs.
    // Set is applied after clear, so a same-edge set of a register wins.
    always_comb begin
        set_mask = '0;
        if (issue && in_rd_en) begin
            set_mask[in_rd_rn] = 1'b1;
        end
        if (issue && in_rd2_en) begin
            set_mask[in_rd2_rn] = 1'b1;
        end

        reg_busy_d    = (reg_busy_q & ~wb_clear_mask) | set_mask;
        reg_busy_d[0] = 1'b0;

        unit_en_d   = issue ? (NUM_UNITS'(1) << in_unit) : '0;
        ex_rd_rn_d  = issue ? in_rd_rn  : ex_rd_rn_q;
        ex_rd2_rn_d = issue ? in_rd2_rn : ex_rd2_rn_q;
        ex_rd_en_d  = issue & in_rd_en;
        ex_rd2_en_d = issue & in_rd2_en;

        stall_cnt_d = stall_cnt_q;
        if (in_valid && !issue && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_busy_q  <= '0;
            unit_en_q   <= '0;
            ex_rd_rn_q  <= '0;
            ex_rd2_rn_q <= '0;
            ex_rd_en_q  <= 1'b0;
            ex_rd2_en_q <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            reg_busy_q  <= reg_busy_d;
            unit_en_q   <= unit_en_d;
            ex_rd_rn_q  <= ex_rd_rn_d;
            ex_rd2_rn_q <= ex_rd2_rn_d;
            ex_rd_en_q  <= ex_rd_en_d;
            ex_rd2_en_q <= ex_rd2_en_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign in_ready  = issue;
    assign unit_en   = unit_en_q;
    assign ex_rd_rn  = ex_rd_rn_q;
    assign ex_rd2_rn = ex_rd2_rn_q;
    assign ex_rd_en  = ex_rd_en_q;
    assign ex_rd2_en = ex_rd2_en_q;
    assign reg_busy  = reg_busy_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_issue_scoreboard
//
// Directed bench for issue_scoreboard (default parameters). Each expected
// issue is pushed into a queue when the bench drives an instruction it
// expects to be accepted; a separate monitor pops and compares whenever the
// DUT pulses unit_en. Busy table, in_ready and stall_cnt are checked
// directly at chosen points. Expectations follow ISSUE_WB_BYPASS_EN.
// ---------------------------------------------------------------------------
module tb_issue_scoreboard;

`ifdef ISSUE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [4:0] unit_en;
        logic [5:0] rd;
        logic [5:0] rd2;
        logic       rd_en;
        logic       rd2_en;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_unit;
    logic [5:0]  in_rs1_rn, in_rs2_rn, in_rd_rn, in_rd2_rn;
    logic        in_rs1_en, in_rs2_en, in_rd_en, in_rd2_en;
    logic [4:0]  unit_busy;
    logic [11:0] wb_rn;
    logic [1:0]  wb_en;
    logic [4:0]  unit_en;
    logic [5:0]  ex_rd_rn, ex_rd2_rn;
    logic        ex_rd_en, ex_rd2_en;
    logic [63:0] reg_busy;
    logic [15:0] stall_cnt;

    int   n_total  = 0;
    int   n_passed = 0;
    int   exp_stall = 0;
    exp_t exp_q[$];

    issue_scoreboard dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_unit   (in_unit),
        .in_rs1_rn (in_rs1_rn),
        .in_rs2_rn (in_rs2_rn),
        .in_rs1_en (in_rs1_en),
        .in_rs2_en (in_rs2_en),
        .in_rd_rn  (in_rd_rn),
        .in_rd2_rn (in_rd2_rn),
        .in_rd_en  (in_rd_en),
        .in_rd2_en (in_rd2_en),
        .unit_busy (unit_busy),
        .wb_rn     (wb_rn),
        .wb_en     (wb_en),
        .unit_en   (unit_en),
        .ex_rd_rn  (ex_rd_rn),
        .ex_rd2_rn (ex_rd2_rn),
        .ex_rd_en  (ex_rd_en),
        .ex_rd2_en (ex_rd2_en),
        .reg_busy  (reg_busy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every unit_en pulse must match the oldest expected issue.
    always @(negedge clk) begin
        if (unit_en != 5'b0) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("[TB] FAIL unexpected_issue: got unit_en 0x%0h expected no issue at %0t", unit_en, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("issue_unit_en", 64'(unit_en), 64'(e.unit_en));
                checkOutput("issue_ex_fields",
                            64'({ex_rd_rn, ex_rd2_rn, ex_rd_en, ex_rd2_en}),
                            64'({e.rd, e.rd2, e.rd_en, e.rd2_en}));
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [2:0] u,
                                 input logic [5:0] rs1, input logic rs1e,
                                 input logic [5:0] rs2, input logic rs2e,
                                 input logic [5:0] rd,  input logic rde,
                                 input logic [5:0] rd2, input logic rd2e);
        in_valid  = v;
        in_unit   = u;
        in_rs1_rn = rs1;
        in_rs1_en = rs1e;
        in_rs2_rn = rs2;
        in_rs2_en = rs2e;
        in_rd_rn  = rd;
        in_rd_en  = rde;
        in_rd2_rn = rd2;
        in_rd2_en = rd2e;
    endtask

    task automatic setWb(input logic [1:0] en, input logic [5:0] rn1, input logic [5:0] rn0);
        wb_en = en;
        wb_rn = {rn1, rn0};
    endtask

    // One clock: check in_ready mid-cycle, record expected issue or stall,
    // then advance to just after the next rising edge.
    task automatic runCycle(input string name, input logic exp_ready);
        exp_t e;
        @(negedge clk);
        checkOutput(name, 64'(in_ready), 64'(exp_ready));
        if (exp_ready) begin
            e.unit_en = 5'b00001 << in_unit;
            e.rd      = in_rd_rn;
            e.rd2     = in_rd2_rn;
            e.rd_en   = in_rd_en;
            e.rd2_en  = in_rd2_en;
            exp_q.push_back(e);
        end else if (in_valid) begin
            exp_stall++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        unit_busy = 5'b0;
        setWb(2'b00, 0, 0);
        idle();
        #12;
        checkOutput("reset_busy",  reg_busy, 64'h0);
        checkOutput("reset_unit_en", 64'(unit_en), 64'h0);
        checkOutput("reset_ex", 64'({ex_rd_rn, ex_rd2_rn, ex_rd_en, ex_rd2_en}), 64'h0);
        checkOutput("reset_stall", 64'(stall_cnt), 64'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic issue: unit 0, rd=5, rs1=3.
        applyStimulus(1, 0, 3, 1, 0, 0, 5, 1, 0, 0);
        runCycle("basic_ready", 1);
        idle();
        checkOutput("basic_busy", reg_busy, 64'h1 << 5);

        // RAW on r5, resolved by writeback of r5.
        applyStimulus(1, 1, 5, 1, 0, 0, 6, 1, 0, 0);
        runCycle("raw_stall", 0);
        checkOutput("raw_stall_cnt1", 64'(stall_cnt), 64'd1);
        setWb(2'b01, 0, 5);
        runCycle("raw_wb_cycle", BYP);
        setWb(2'b00, 0, 0);
        if (!BYP) runCycle("raw_after_wb", 1);
        idle();
        checkOutput("raw_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
        checkOutput("raw_busy", reg_busy, 64'h1 << 6);

        // WAW on r7 via rd2, writeback on port 1; reissue sets r7 again.
        applyStimulus(1, 2, 0, 0, 0, 0, 7, 1, 0, 0);
        runCycle("waw_producer", 1);
        applyStimulus(1, 3, 0, 0, 0, 0, 8, 1, 7, 1);
        runCycle("waw_stall_a", 0);
        runCycle("waw_stall_b", 0);
        setWb(2'b10, 7, 0);
        runCycle("waw_wb_cycle", BYP);
        setWb(2'b00, 0, 0);
        if (!BYP) runCycle("waw_after_wb", 1);
        idle();
        checkOutput("waw_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
        checkOutput("waw_busy", reg_busy, (64'h1 << 6) | (64'h1 << 7) | (64'h1 << 8));

        // Two-port writeback, then duplicate register on both ports.
        setWb(2'b11, 8, 6);
        runCycle("wb_two_ports", 0);
        checkOutput("wb_two_busy", reg_busy, 64'h1 << 7);
        setWb(2'b11, 7, 7);
        runCycle("wb_dup", 0);
        setWb(2'b00, 0, 0);
        checkOutput("wb_dup_busy", reg_busy, 64'h0);

        // r0 never becomes busy; reading r0 never stalls (back-to-back).
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        runCycle("r0_write", 1);
        applyStimulus(1, 1, 0, 1, 0, 1, 9, 1, 0, 0);
        runCycle("r0_read", 1);
        idle();
        checkOutput("r0_busy", reg_busy, 64'h1 << 9);
        setWb(2'b01, 0, 9);
        runCycle("r0_cleanup", 0);
        setWb(2'b00, 0, 0);

        // rd == rd2 sets a single bit.
        applyStimulus(1, 4, 0, 0, 0, 0, 10, 1, 10, 1);
        runCycle("same_rd", 1);
        idle();
        checkOutput("same_rd_busy", reg_busy, 64'h1 << 10);
        setWb(2'b01, 0, 10);
        runCycle("same_rd_cleanup", 0);
        setWb(2'b00, 0, 0);

        // Busy unit stalls; retarget to a free unit.
        unit_busy = 5'b00100;
        applyStimulus(1, 2, 0, 0, 0, 0, 11, 1, 0, 0);
        runCycle("unit_busy_stall", 0);
        in_unit = 3'd3;
        runCycle("unit_free_issue", 1);
        idle();
        unit_busy = 5'b0;
        setWb(2'b01, 0, 11);
        runCycle("unit_cleanup", 0);
        setWb(2'b00, 0, 0);

        // Out-of-range unit indices never issue.
        applyStimulus(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        runCycle("unit5_oor", 0);
        in_unit = 3'd7;
        runCycle("unit7_oor", 0);
        idle();
        checkOutput("oor_stall_cnt", 64'(stall_cnt), 64'(exp_stall));

        // Back-to-back independent issues.
        applyStimulus(1, 0, 0, 0, 0, 0, 12, 1, 0, 0);
        runCycle("b2b_first", 1);
        applyStimulus(1, 1, 0, 0, 0, 0, 13, 1, 0, 0);
        runCycle("b2b_second", 1);
        idle();
        checkOutput("b2b_busy", reg_busy, (64'h1 << 12) | (64'h1 << 13));
        setWb(2'b11, 13, 12);
        runCycle("b2b_cleanup", 0);
        setWb(2'b00, 0, 0);

        // Saturation of stall_cnt, then asynchronous reset mid-operation.
        applyStimulus(1, 4, 0, 0, 0, 0, 20, 1, 0, 0);
        runCycle("sat_setup", 1);
        unit_busy = 5'b00001;
        applyStimulus(1, 0, 0, 0, 0, 0, 22, 1, 0, 0);
        repeat (70000) @(posedge clk);
        #1;
        checkOutput("stall_saturated", 64'(stall_cnt), 64'hFFFF);
        in_unit  = 3'd1;
        in_rd_rn = 6'd21;
        @(posedge clk);
        #1;
        idle();
        unit_busy = 5'b0;
        checkOutput("pre_reset_unit_en", 64'(unit_en), 64'h2);
        checkOutput("pre_reset_busy", reg_busy, (64'h1 << 20) | (64'h1 << 21));
        checkOutput("pre_reset_stall", 64'(stall_cnt), 64'hFFFF);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_stall", 64'(stall_cnt), 64'h0);
        checkOutput("async_rst_busy", reg_busy, 64'h0);
        checkOutput("async_rst_unit_en", 64'(unit_en), 64'h0);
        #6;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        checkOutput("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
